snake_input_ctrl: RTL and testbench

SNAKE_INPUT_CTRL -- requirements
Module: snake_input_ctrl

---
 rtl/snake_input_ctrl_if.sv | 40 ++++
 rtl/snake_input_ctrl.sv | 164 ++++++++++++++++
 tb/tb_snake_input_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/snake_input_ctrl_if.sv
// snake_input_ctrl_if
//   Groups the pushbutton inputs, the game-step strobe and the steering
//   outputs of snake_input_ctrl into one bundle.
//
//   KEY         [3:2] raw pushbuttons, active-low (KEY[3] left, KEY[2] right)
//   tick              one-cycle game-step strobe
//   heading     [1:0] current direction: 00 up, 01 right, 10 down, 11 left
//   turn_valid        one-cycle pulse in the cycle heading takes a new value
//   queue_count [1:0] number of pending turns
//   overflow          sticky "turn dropped" flag
//
//   Modports: master = game logic / bench side, slave = snake_input_ctrl.
//   There is no valid/ready handshake here: tick is a plain strobe that the
//   controller always accepts, and turn_valid is a qualifier-only pulse.
interface snake_input_ctrl_if;
    logic [3:2] KEY;
    logic       tick;
    logic [1:0] heading;
    logic       turn_valid;
    logic [1:0] queue_count;
    logic       overflow;

    modport master (
        output KEY,
        output tick,
        input  heading,
        input  turn_valid,
        input  queue_count,
        input  overflow
    );

    modport slave (
        input  KEY,
        input  tick,
        output heading,
        output turn_valid,
        output queue_count,
        output overflow
    );
endinterface

// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl
//   Turns two raw pushbuttons into queued left/right turns and applies one
//   turn to the snake heading on every game tick.
//
//   Parameter DEBOUNCE_CYCLES : stable cycles needed before a debounced key
//                               level changes.
//   Ports:
//     CLOCK_50 : the only clock, rising edge
//     reset    : synchronous, active-high
//     bus      : snake_input_ctrl_if.slave (KEY, tick in; heading,
//                turn_valid, queue_count, overflow out)
//
//   Build option SNAKE_TURN_QUEUE_EN:
//     defined   -> 2-deep turn FIFO with sticky overflow flag
//     undefined -> single pending-turn slot, newest press overwrites it,
//                  overflow is constant 0
//
//   Key index inside this block: 1 = KEY[3] (left), 0 = KEY[2] (right).
//   A stored turn bit is 1 for right, 0 for left.
module snake_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    snake_input_ctrl_if.slave bus
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [CW-1:0] cnt [2];

    logic [1:0]    heading_q;
    logic          turn_valid_q;
    logic [1:0]    q_cnt;
    logic          q0;

    logic [1:0]    press;
    logic          push;
    logic          push_dir;
    logic          pop;

    // A press is the cycle in which a released key's debounce counter
    // completes, i.e. the same edge at which the debounced level drops.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            press[i] = deb[i] && !sync2[i] && (cnt[i] == CNT_LAST);
        end
        // Simultaneous left and right cancel each other out.
        push     = press[0] ^ press[1];
        push_dir = press[0];
    end

    // Synchronizers, debouncers and heading update.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1        <= 2'b11;
            sync2        <= 2'b11;
            deb          <= 2'b11;
            cnt[0]       <= '0;
            cnt[1]       <= '0;
            heading_q    <= 2'b01;
            turn_valid_q <= 1'b0;
        end else begin
            sync1 <= bus.KEY;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            // q0 is the oldest turn as it stood before this cycle's pop.
            if (pop) begin
                heading_q    <= q0 ? heading_q + 2'd1 : heading_q - 2'd1;
                turn_valid_q <= 1'b1;
            end else begin
                turn_valid_q <= 1'b0;
            end
        end
    end

`ifdef SNAKE_TURN_QUEUE_EN
    logic       q1;
    logic       overflow_q;
    logic [1:0] cnt_after_pop;
    logic [1:0] nxt_cnt;
    logic       nxt_q0;
    logic       nxt_q1;
    logic       ovf_set;

    assign pop = bus.tick && (q_cnt != 2'd0);

    // Pop is applied first; the push then lands in the first free slot of
    // the shifted queue, so a full queue with a tick still takes the push.
    always_comb begin
        cnt_after_pop = q_cnt - {1'b0, pop};
        nxt_q0        = pop ? q1 : q0;
        nxt_q1        = q1;
        nxt_cnt       = cnt_after_pop;
        ovf_set       = 1'b0;
        if (push) begin
            if (cnt_after_pop == 2'd0) begin
                nxt_q0  = push_dir;
                nxt_cnt = 2'd1;
            end else if (cnt_after_pop == 2'd1) begin
                nxt_q1  = push_dir;
                nxt_cnt = 2'd2;
            end else begin
                ovf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            q_cnt      <= 2'd0;
            q0         <= 1'b0;
            q1         <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            q_cnt <= nxt_cnt;
            q0    <= nxt_q0;
            q1    <= nxt_q1;
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.overflow = overflow_q;
`else
    assign pop = bus.tick && q_cnt[0];

    // Single slot: a new press replaces whatever turn was pending.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            q_cnt <= 2'd0;
            q0    <= 1'b0;
        end else begin
            if (push) begin
                q_cnt <= 2'd1;
                q0    <= push_dir;
            end else if (pop) begin
                q_cnt <= 2'd0;
            end
        end
    end

    assign bus.overflow = 1'b0;
`endif

    assign bus.heading     = heading_q;
    assign bus.turn_valid  = turn_valid_q;
    assign bus.queue_count = q_cnt;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// tb_snake_input_ctrl
//   Directed bench for snake_input_ctrl with DEBOUNCE_CYCLES = 4.
//   Expected values depend on SNAKE_TURN_QUEUE_EN and are chosen at compile
//   time. Inputs change and outputs are sampled 1 ns after a rising edge.
module tb_snake_input_ctrl;

`ifdef SNAKE_TURN_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    snake_input_ctrl_if bus ();

    snake_input_ctrl #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .bus     (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    // Hold the given active-low key pattern long enough for one event,
    // then release and let the debouncer settle back to released.
    task automatic press(input logic [3:2] k);
        bus.KEY = k;
        cyc(7);
        bus.KEY = 2'b11;
        cyc(8);
    endtask

    // One tick; returns with outputs of the cycle right after the tick edge.
    task automatic do_tick();
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        bus.KEY  = 2'b11;
        bus.tick = 1'b0;

        // Reset values
        do_reset();
        chk("rst_heading", bus.heading, 2'b01);
        chk("rst_tv", {1'b0, bus.turn_valid}, 2'b00);
        chk("rst_qc", bus.queue_count, 2'd0);
        chk("rst_ovf", {1'b0, bus.overflow}, 2'b00);

        // Right press latency: event at the 6th edge after the fall
        bus.KEY = 2'b10;
        cyc(5);
        chk("lat_qc_before", bus.queue_count, 2'd0);
        cyc(1);
        chk("lat_qc_at", bus.queue_count, 2'd1);
        bus.KEY = 2'b11;
        cyc(8);
        chk("release_no_event", bus.queue_count, 2'd1);
        chk("pre_tick_tv", {1'b0, bus.turn_valid}, 2'b00);
        do_tick();
        chk("r_tick_heading", bus.heading, 2'b10);
        chk("r_tick_tv", {1'b0, bus.turn_valid}, 2'b01);
        chk("r_tick_qc", bus.queue_count, 2'd0);
        cyc(1);
        chk("tv_one_cycle", {1'b0, bus.turn_valid}, 2'b00);
        chk("heading_hold", bus.heading, 2'b10);

        // Glitch of 3 cycles on the left key
        do_reset();
        bus.KEY = 2'b01;
        cyc(3);
        bus.KEY = 2'b11;
        cyc(10);
        chk("glitch_qc", bus.queue_count, 2'd0);
        chk("glitch_heading", bus.heading, 2'b01);

        // Three right presses without a tick
        do_reset();
        press(2'b10);
        press(2'b10);
        press(2'b10);
        chk("three_r_qc", bus.queue_count, QEN ? 2'd2 : 2'd1);
        chk("three_r_ovf", {1'b0, bus.overflow}, {1'b0, QEN});
        do_tick();
        chk("three_r_t1", bus.heading, 2'b10);
        cyc(1);
        do_tick();
        chk("three_r_t2", bus.heading, QEN ? 2'b11 : 2'b10);
        chk("three_r_t2_tv", {1'b0, bus.turn_valid}, {1'b0, QEN});
        cyc(1);
        do_tick();
        chk("empty_tick_heading", bus.heading, QEN ? 2'b11 : 2'b10);
        chk("empty_tick_tv", {1'b0, bus.turn_valid}, 2'b00);
        chk("ovf_sticky", {1'b0, bus.overflow}, {1'b0, QEN});

        // Push coinciding with a tick while full
        do_reset();
        press(2'b10);
        press(2'b10);
        bus.KEY = 2'b10;
        cyc(5);
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
        chk("push_tick_qc", bus.queue_count, QEN ? 2'd2 : 2'd1);
        chk("push_tick_ovf", {1'b0, bus.overflow}, 2'b00);
        chk("push_tick_heading", bus.heading, 2'b10);
        bus.KEY = 2'b11;
        cyc(8);

        // Both keys in the same cycle are discarded
        do_reset();
        press(2'b00);
        chk("both_qc", bus.queue_count, 2'd0);
        // Left to reach 00, then left wraps to 11, then right wraps to 00
        press(2'b01);
        do_tick();
        chk("l_to_up", bus.heading, 2'b00);
        press(2'b01);
        do_tick();
        chk("l_wrap", bus.heading, 2'b11);
        press(2'b10);
        do_tick();
        chk("r_wrap", bus.heading, 2'b00);

        // Right then left, then one tick
        do_reset();
        press(2'b10);
        press(2'b01);
        do_tick();
        chk("rl_heading", bus.heading, QEN ? 2'b10 : 2'b00);
        chk("rl_qc", bus.queue_count, QEN ? 2'd1 : 2'd0);
        chk("rl_ovf", {1'b0, bus.overflow}, 2'b00);

        // Reset with turns queued and mid-debounce, key held across reset
        bus.KEY = 2'b10;
        cyc(3);
        reset = 1'b1;
        cyc(3);
        chk("mid_rst_qc", bus.queue_count, 2'd0);
        chk("mid_rst_heading", bus.heading, 2'b01);
        reset = 1'b0;
        cyc(4);
        chk("held_qc_early", bus.queue_count, 2'd0);
        cyc(4);
        chk("held_qc_late", bus.queue_count, 2'd1);
        bus.KEY = 2'b11;
        cyc(12);
        chk("held_one_event", bus.queue_count, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
